hpdmc_dq_sequencer: RTL
=======================

Name: hpdmc_dq_sequencer

Overview:
- Cycle-level sequencer for the 16-bit SDR SDRAM data bus, on the core side of the per-bit tristate I/O buffers.
- Generates the per-bit tristate enables and output data, and captures returning read data after CAS latency.
- Is told by the HPDMC command scheduler when a READ or WRITE command issues, then runs the matching data burst.
- Enforces one bus-turnaround cycle after every read burst.

Parameters:
- DW, 16, data bus width; must match the I/O buffer bank width.
- BURST_LEN, 8, beats per burst, legal values 1..8.
- CAS_LATENCY, 2, SDRAM CAS latency in sys_clk cycles, legal values 2 or 3.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- sys_rst  input  1  synchronous active-high reset.
- wr_start  input  1  WRITE command issued this cycle; sampled only when ready=1.
- rd_start  input  1  READ command issued this cycle; sampled only when ready=1.
- ready  output  1  sequencer can accept a start this cycle.
- wr_data  input  DW  current write beat.
- wr_ack  output  1  wr_data sampled this cycle; requester presents the next beat in the next cycle.
- rd_data  output  DW  captured read beat (registered).
- rd_valid  output  1  rd_data valid this cycle.
- collision  output  1  one-cycle pulse: wr_start and rd_start both seen while ready=1.
- dq_t  output  DW  per-bit tristate control to the I/O buffers (1 = high-Z).
- dq_o  output  DW  data to the I/O buffer inputs.
- dq_i  input  DW  data from the I/O buffer outputs.
- dqm  output  DW/8  byte data mask to the SDRAM pins.

Behaviour:
- Reset values (sys_rst=1 at a clock edge; dominates any in-flight burst, no residual beats):
  - state=IDLE; dq_t all ones; dq_o=0; dqm=0.
  - rd_valid=0; rd_data=0; wr_ack=0; collision=0; ready=0 in the reset cycle.
  - ready=1 from the first cycle after reset deasserts.
- States: IDLE, WRITE, RD_WAIT, READ, TURN. ready=1 only in IDLE.
- IDLE:
  - wr_start=1 -> WRITE, beat counter=0, wr_ack=1 combinationally in the same cycle N.
  - rd_start=1 (and wr_start=0) -> RD_WAIT, latency counter=CAS_LATENCY.
  - Both high -> the write is taken, the read is dropped, and collision pulses in cycle N+1.
  - Starts while ready=0 are ignored, with no collision pulse.
- WRITE:
  - In cycles N+1..N+BURST_LEN: dq_t=all zeros and dq_o=beat k, where beat k is wr_data sampled in cycle N+k-1.
  - wr_ack is high in cycles N..N+BURST_LEN-1, giving exactly BURST_LEN acks.
  - After the last driven beat, dq_t returns to all ones and the state goes to IDLE, so ready=1 in cycle N+BURST_LEN+1.
  - No turnaround is needed after a write: the controller stops driving before the SDRAM does.
- RD_WAIT / READ:
  - dq_t stays all ones throughout.
  - dq_i is registered every cycle; rd_data is that register.
  - rd_valid is high in cycles N+CAS_LATENCY+1 .. N+CAS_LATENCY+BURST_LEN (one cycle for the input register).
  - After the last valid beat, go to TURN.
- TURN: one cycle, dq_t all ones, ready=0; then IDLE.
- Counters are 3-bit and wrap-free: the burst counter compares against BURST_LEN-1 and never overflows.
- Back-to-back operation:
  - write->read minimum spacing is BURST_LEN+1 cycles between starts.
  - read->any minimum spacing is CAS_LATENCY+BURST_LEN+2 cycles between starts.

Optional Feature:
- Macro: HPDMC_DQ_MASK_EN.
- Defined:
  - Adds input wr_be (DW/8 wide), sampled together with wr_data.
  - dqm=~wr_be, registered and aligned to dq_o during WRITE beats.
  - dqm=0 during reads.
  - dqm is forced to all ones in the TURN cycle and in reset.
- Not defined: no wr_be port; dqm tied to 0 permanently.

Test Plan:
- Reset: hold sys_rst 3 cycles mid-read burst (beat 2 of 8) -> dq_t=16'hFFFF, rd_valid=0 at once; no further rd_valid; ready=1 one cycle after release.
- Write, BURST_LEN=8: wr_start at cycle 10, wr_data=16'h1000+k -> wr_ack in cycles 10..17; dq_t=0 and dq_o=16'h1000..16'h1007 in cycles 11..18; ready=1 at cycle 19.
- Read, CAS_LATENCY=2: rd_start at cycle 10, model drives dq_i=16'hA000+k starting cycle 12 -> rd_valid in cycles 13..20 with rd_data 16'hA000..16'hA007; TURN in cycle 21; ready=1 at cycle 22.
- Read, CAS_LATENCY=3, BURST_LEN=1: rd_start at cycle 5 -> a single rd_valid at cycle 9; dq_t all ones throughout.
- Collision: wr_start=rd_start=1 in IDLE -> write burst runs, collision=1 for one cycle, no rd_valid; starts asserted while ready=0 -> no effect.
- HPDMC_DQ_MASK_EN defined: wr_be=2'b01 on beat 3 -> dqm=2'b10 in that beat's drive cycle, dqm=0 on the other beats, and dqm=2'b11 in TURN after a subsequent read.

Source files
------------

// File: rtl/hpdmc_dq_sequencer.sv
// SDR SDRAM DQ bus sequencer: drives tristate enables/data for write bursts, captures read beats after CAS latency.
// Latency: write beat k on dq_o one cycle after its wr_ack; read beat valid CAS_LATENCY+1 cycles after rd_start plus beat index.
// Backpressure: starts accepted only while ready=1; one turnaround cycle after each read burst. Optional HPDMC_DQ_MASK_EN adds wr_be/dqm.
`timescale 1ns/1ps
module hpdmc_dq_sequencer #(
    parameter int DW          = 16,
    parameter int BURST_LEN   = 8,
    parameter int CAS_LATENCY = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_start,
    input  logic              rd_start,
    output logic              ready,
    input  logic [DW-1:0]     wr_data,
`ifdef HPDMC_DQ_MASK_EN
    input  logic [DW/8-1:0]   wr_be,
`endif
    output logic              wr_ack,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              collision,
    output logic [DW-1:0]     dq_t,
    output logic [DW-1:0]     dq_o,
    input  logic [DW-1:0]     dq_i,
    output logic [DW/8-1:0]   dqm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_READ,
        S_TURN
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);
    localparam logic [2:0] CL_LOAD   = 3'(CAS_LATENCY);

    state_t     state;
    logic [2:0] cnt;       // beat index in WRITE/READ, remaining latency in RD_WAIT
    logic       ready_q;

    assign ready = ready_q;

    // Acks the beat presented this cycle: the start beat in IDLE plus every beat but the last in WRITE.
    always_comb begin
        wr_ack = 1'b0;
        if (!sys_rst) begin
            if (state == S_IDLE)
                wr_ack = ready_q & wr_start;
            else if (state == S_WRITE)
                wr_ack = (cnt != LAST_BEAT);
        end
    end

    // Main sequencer: state, counters, and registered bus controls.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            ready_q   <= 1'b0;
            dq_t      <= '1;
            dq_o      <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            collision <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!ready_q) begin
                        // first cycle out of reset: open for business next cycle
                        ready_q <= 1'b1;
                    end else if (wr_start) begin
                        // write wins a simultaneous start; the read is dropped and flagged
                        state     <= S_WRITE;
                        cnt       <= 3'd0;
                        ready_q   <= 1'b0;
                        dq_t      <= '0;
                        dq_o      <= wr_data;
                        collision <= rd_start;
                    end else if (rd_start) begin
                        state   <= S_RD_WAIT;
                        cnt     <= CL_LOAD;
                        ready_q <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (cnt == LAST_BEAT) begin
                        // controller releases the bus before the SDRAM could drive it, so no turnaround
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        dq_t    <= '1;
                        dq_o    <= '0;
                    end else begin
                        cnt  <= cnt + 3'd1;
                        dq_o <= wr_data;
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == 3'd1) begin
                        // first beat is on dq_i now and lands in rd_data next cycle
                        state    <= S_READ;
                        cnt      <= 3'd0;
                        rd_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_READ: begin
                    if (cnt == LAST_BEAT) begin
                        state    <= S_TURN;
                        rd_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_TURN: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    dq_t    <= '1;
                end
            endcase
        end
    end

    // Input register on the returning data; rd_valid qualifies it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            rd_data <= '0;
        else
            rd_data <= dq_i;
    end

`ifdef HPDMC_DQ_MASK_EN
    // Byte mask travels with each write beat; forced high across the post-read turnaround.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dqm <= '1;
        end else begin
            case (state)
                S_IDLE:  dqm <= (ready_q && wr_start) ? ~wr_be : '0;
                S_WRITE: dqm <= (cnt == LAST_BEAT) ? '0 : ~wr_be;
                S_READ:  dqm <= (cnt == LAST_BEAT) ? '1 : '0;
                default: dqm <= '0;
            endcase
        end
    end
`else
    assign dqm = '0;
`endif

endmodule
